// File: rtl/de0_mc_pkg.sv
// Shared definitions for the DE0 SDRAM controller host initiator.
// Provides:
//   - mc_state_e : controller-side command sequencer states
//   - DataSizeDef / AddrSizeDef : default data and word-address widths
//   - BlenW / BeatW : burst-length field width and beat-counter width
//   - IdleCntW / IdleCntMax : idle-cycle counter width and saturation value
//   - idle_inc() : saturating increment for the idle counter
package de0_mc_pkg;

    localparam int unsigned DataSizeDef = 16;
    localparam int unsigned AddrSizeDef = 24;

    localparam int unsigned BlenW = 3;
    // One extra bit so len+1 (up to 8) and surplus acks fit without wrapping.
    localparam int unsigned BeatW = BlenW + 1;

    localparam int unsigned IdleCntW = 4;
    localparam logic [IdleCntW-1:0] IdleCntMax = '1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCmd   = 2'd1,
        StXfer  = 2'd2,
        StRwait = 2'd3
    } mc_state_e;

    function automatic logic [IdleCntW-1:0] idle_inc(input logic [IdleCntW-1:0] v);
        return (v == IdleCntMax) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/de0_mc_host.sv
// Host-side initiator for the mc_* command interface of the DE0 SDR SDRAM controller.
// Takes single/burst read/write requests from one host, interleaves refreshes requested
// by the controller, issues commands with a strobe/ready handshake and steers per-beat data.
//
// Ports:
//   mc_clk_i, mc_rst_n      clock (rising edge), asynchronous active-low reset
//   hst_req_i/we/adr/len/sel/dat_i   host request, sampled in IDLE
//   hst_wack_o              write beat consumed (combinational from mc_ack_i)
//   hst_dat_o, hst_rval_o   registered read data and its one-cycle valid
//   hst_done_o, hst_err_o   end-of-command pulse, error if ack count != len+1
//   hst_busy_o              sequencer not idle
//   mc_stb_o, mc_rfsh_o, mc_wreq_o, mc_blen_o, mc_adr_o, mc_sel_o, mc_dat_o
//                           command to the controller
//   mc_dat_i, mc_rdy_i, mc_ack_i, mc_done_i   controller responses
//   mc_lref_i, mc_href_i    low/high-priority refresh requests
module de0_mc_host
    import de0_mc_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DataSizeDef,
    parameter int unsigned ADDR_SIZE = AddrSizeDef,
    parameter int unsigned LREF_IDLE = 4
) (
    input  logic                   mc_clk_i,
    input  logic                   mc_rst_n,

    input  logic                   hst_req_i,
    input  logic                   hst_we_i,
    input  logic [ADDR_SIZE-1:0]   hst_adr_i,
    input  logic [BlenW-1:0]       hst_len_i,
    input  logic [DATA_SIZE/8-1:0] hst_sel_i,
    input  logic [DATA_SIZE-1:0]   hst_dat_i,
    output logic                   hst_wack_o,
    output logic [DATA_SIZE-1:0]   hst_dat_o,
    output logic                   hst_rval_o,
    output logic                   hst_done_o,
    output logic                   hst_err_o,
    output logic                   hst_busy_o,

    output logic                   mc_stb_o,
    output logic                   mc_rfsh_o,
    output logic                   mc_wreq_o,
    output logic [BlenW-1:0]       mc_blen_o,
    output logic [ADDR_SIZE-1:0]   mc_adr_o,
    output logic [DATA_SIZE/8-1:0] mc_sel_o,
    output logic [DATA_SIZE-1:0]   mc_dat_o,
    input  logic [DATA_SIZE-1:0]   mc_dat_i,
    input  logic                   mc_rdy_i,
    input  logic                   mc_ack_i,
    input  logic                   mc_done_i,
    input  logic                   mc_lref_i,
    input  logic                   mc_href_i
);

    localparam logic [IdleCntW-1:0] LrefThr = IdleCntW'(LREF_IDLE);

    mc_state_e              r_state;
    mc_state_e              w_state_nx;
    logic [IdleCntW-1:0]    r_idle_cnt;
    logic [BeatW-1:0]       r_beat_cnt;

    logic                   r_rfsh;
    logic                   r_wreq;
    logic [BlenW-1:0]       r_blen;
    logic [ADDR_SIZE-1:0]   r_adr;
    logic [DATA_SIZE/8-1:0] r_sel;

    logic [DATA_SIZE-1:0]   r_rdat;
    logic                   r_rval;
    logic                   r_done;
    logic                   r_err;

    logic                   w_ld_rfsh;
    logic                   w_ld_host;
    logic                   w_in_xfer;
    logic                   w_ack_x;
    logic                   w_beat_ok;
    logic [BeatW-1:0]       w_beat_inc;
    logic [BeatW-1:0]       w_beats_fin;
    logic [BeatW-1:0]       w_len_p1;

    // ---------------------------------------------------------------------------------------
    // Next-state and IDLE arbitration: high-priority refresh, then host, then low-priority
    // refresh once the bus has been quiet long enough.
    // ---------------------------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_ld_rfsh  = 1'b0;
        w_ld_host  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (mc_href_i) begin
                    w_ld_rfsh  = 1'b1;
                    w_state_nx = StCmd;
                end else if (hst_req_i) begin
                    w_ld_host  = 1'b1;
                    w_state_nx = StCmd;
                end else if (mc_lref_i && (r_idle_cnt >= LrefThr)) begin
                    w_ld_rfsh  = 1'b1;
                    w_state_nx = StCmd;
                end
            end
            StCmd: begin
                if (mc_rdy_i) begin
                    w_state_nx = r_rfsh ? StRwait : StXfer;
                end
            end
            StXfer: begin
                if (mc_done_i) begin
                    w_state_nx = StIdle;
                end
            end
            StRwait: begin
                if (mc_done_i) begin
                    w_state_nx = StIdle;
                end
            end
            default: w_state_nx = StIdle;
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // Beat accounting. Acks past len+1 still advance the counter (saturating) so the final
    // count exceeds len+1 and the mismatch check flags them.
    // ---------------------------------------------------------------------------------------
    always_comb begin
        w_in_xfer   = (r_state == StXfer);
        w_ack_x     = w_in_xfer && mc_ack_i;
        w_len_p1    = {1'b0, r_blen} + BeatW'(1);
        w_beat_ok   = w_ack_x && (r_beat_cnt < w_len_p1);
        w_beat_inc  = (r_beat_cnt == '1) ? r_beat_cnt : r_beat_cnt + BeatW'(1);
        // An ack coinciding with done is counted before the final comparison.
        w_beats_fin = w_ack_x ? w_beat_inc : r_beat_cnt;
    end

    always_ff @(posedge mc_clk_i or negedge mc_rst_n) begin
        if (!mc_rst_n) begin
            r_state    <= StIdle;
            r_idle_cnt <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == StIdle) begin
                r_idle_cnt <= (w_state_nx == StIdle) ? idle_inc(r_idle_cnt) : '0;
            end
            if (w_ld_rfsh || w_ld_host) begin
                r_beat_cnt <= '0;
            end else if (w_ack_x) begin
                r_beat_cnt <= w_beat_inc;
            end
        end
    end

    // Command fields: held stable from load until the next command is loaded.
    always_ff @(posedge mc_clk_i or negedge mc_rst_n) begin
        if (!mc_rst_n) begin
            r_rfsh <= 1'b0;
            r_wreq <= 1'b0;
            r_blen <= '0;
            r_adr  <= '0;
            r_sel  <= '0;
        end else begin
            if (w_ld_rfsh) begin
                r_rfsh <= 1'b1;
                r_wreq <= 1'b0;
            end else if (w_ld_host) begin
                r_rfsh <= 1'b0;
                r_wreq <= hst_we_i;
                r_blen <= hst_len_i;
                r_adr  <= hst_adr_i;
                r_sel  <= hst_sel_i;
            end else if ((r_state == StRwait) && mc_done_i) begin
                r_rfsh <= 1'b0;
            end
        end
    end

    // Host-facing registered outputs: read data, its valid, and end-of-command pulses.
    always_ff @(posedge mc_clk_i or negedge mc_rst_n) begin
        if (!mc_rst_n) begin
            r_rdat <= '0;
            r_rval <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_rval <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_beat_ok && !r_wreq) begin
                r_rdat <= mc_dat_i;
                r_rval <= 1'b1;
            end
            if (w_in_xfer && mc_done_i) begin
                r_done <= 1'b1;
                r_err  <= (w_beats_fin != w_len_p1);
            end
        end
    end

    always_comb begin
        mc_stb_o   = (r_state == StCmd);
        mc_rfsh_o  = r_rfsh;
        mc_wreq_o  = r_wreq;
        mc_blen_o  = r_blen;
        mc_adr_o   = r_adr;
        mc_sel_o   = r_sel;
        mc_dat_o   = (w_in_xfer && r_wreq) ? hst_dat_i : '0;
        hst_wack_o = w_beat_ok && r_wreq;
        hst_dat_o  = r_rdat;
        hst_rval_o = r_rval;
        hst_done_o = r_done;
        hst_err_o  = r_err;
        hst_busy_o = (r_state != StIdle);
    end

endmodule

// File: tb/tb_de0_mc_host.sv
// Self-checking bench for de0_mc_host: a command-level reference model plus directed
// scenarios with literal expectations.
module tb_de0_mc_host;

    localparam int LREF = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [23:0] adr = '0;
    logic [2:0]  len = '0;
    logic [1:0]  sel = '0;
    logic [15:0] hdat = '0, mdat = '0;
    logic        rdy = 1'b0, ack = 1'b0, mdone = 1'b0, lref = 1'b0, href = 1'b0;

    logic        wack, rval, hdone, herr, busy, stb, rfsh, wreq;
    logic [15:0] hdat_o, mdat_o;
    logic [2:0]  blen;
    logic [23:0] madr;
    logic [1:0]  msel;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    de0_mc_host #(.DATA_SIZE(16), .ADDR_SIZE(24), .LREF_IDLE(LREF)) dut (
        .mc_clk_i(clk), .mc_rst_n(rst_n),
        .hst_req_i(req), .hst_we_i(we), .hst_adr_i(adr), .hst_len_i(len), .hst_sel_i(sel),
        .hst_dat_i(hdat), .hst_wack_o(wack), .hst_dat_o(hdat_o), .hst_rval_o(rval),
        .hst_done_o(hdone), .hst_err_o(herr), .hst_busy_o(busy),
        .mc_stb_o(stb), .mc_rfsh_o(rfsh), .mc_wreq_o(wreq), .mc_blen_o(blen),
        .mc_adr_o(madr), .mc_sel_o(msel), .mc_dat_o(mdat_o), .mc_dat_i(mdat),
        .mc_rdy_i(rdy), .mc_ack_i(ack), .mc_done_i(mdone), .mc_lref_i(lref),
        .mc_href_i(href)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endfunction

    // ---------------- Reference model (command level) ----------------
    bit          m_active = 0, m_hs = 0, m_rcmd = 0;
    bit          m_rfsh = 0, m_wreq = 0, m_rval = 0, m_done = 0, m_err = 0;
    logic [2:0]  m_blen = '0;
    logic [23:0] m_adr = '0;
    logic [1:0]  m_sel = '0;
    logic [15:0] m_rdat = '0;
    int          m_idle = 0, m_beats = 0, m_len = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 0; m_hs = 0; m_rcmd = 0; m_rfsh = 0; m_wreq = 0;
                m_rval = 0; m_done = 0; m_err = 0; m_blen = '0; m_adr = '0; m_sel = '0;
                m_rdat = '0; m_idle = 0; m_beats = 0; m_len = 0;
            end else begin
                m_rval = 0; m_done = 0; m_err = 0;
                if (!m_active) begin
                    if (href || req || (lref && m_idle >= LREF)) begin
                        m_active = 1; m_hs = 0; m_beats = 0; m_idle = 0;
                        if (!href && req) begin
                            m_rcmd = 0; m_rfsh = 0; m_wreq = we; m_blen = len;
                            m_adr = adr; m_sel = sel; m_len = int'(len);
                        end else begin
                            m_rcmd = 1; m_rfsh = 1; m_wreq = 0;
                        end
                    end else if (m_idle < 15) begin
                        m_idle++;
                    end
                end else if (!m_hs) begin
                    if (rdy) m_hs = 1;
                end else if (m_rcmd) begin
                    if (mdone) begin m_active = 0; m_rfsh = 0; end
                end else begin
                    if (ack) begin
                        if (m_beats < m_len + 1 && !m_wreq) begin m_rval = 1; m_rdat = mdat; end
                        if (m_beats < 15) m_beats++;
                    end
                    if (mdone) begin m_active = 0; m_done = 1; m_err = (m_beats != m_len + 1); end
                end
            end
        end
    end

    // ---------------- Monitor / per-cycle compare ----------------
    int          cyc = 0, n_stb = 0, n_rstb = 0, n_wack = 0, n_rval = 0;
    int          n_done = 0, n_err = 0, n_errdone = 0;
    logic [15:0] rv_dat[$], wd[$];
    int          rv_cyc[$], ack_cyc[$];

    task automatic compare_loop();
        bit x;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                x = m_active && m_hs && !m_rcmd;
                chk("stb", 32'(stb), 32'(m_active && !m_hs));
                chk("busy", 32'(busy), 32'(m_active));
                chk("rfsh", 32'(rfsh), 32'(m_rfsh));
                chk("wreq", 32'(wreq), 32'(m_wreq));
                chk("blen", 32'(blen), 32'(m_blen));
                chk("adr", 32'(madr), 32'(m_adr));
                chk("sel", 32'(msel), 32'(m_sel));
                chk("wack", 32'(wack), 32'(x && m_wreq && ack && (m_beats < m_len + 1)));
                chk("mc_dat", 32'(mdat_o), (x && m_wreq) ? 32'(hdat) : 32'd0);
                chk("rval", 32'(rval), 32'(m_rval));
                chk("hst_dat", 32'(hdat_o), 32'(m_rdat));
                chk("done", 32'(hdone), 32'(m_done));
                chk("err", 32'(herr), 32'(m_err));
                if (stb) n_stb++;
                if (stb && rfsh && !wreq) n_rstb++;
                if (wack) begin n_wack++; wd.push_back(mdat_o); end
                if (rval) begin n_rval++; rv_dat.push_back(hdat_o); rv_cyc.push_back(cyc); end
                if (ack) ack_cyc.push_back(cyc);
                if (hdone) n_done++;
                if (herr) n_err++;
                if (herr && hdone) n_errdone++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Emulated controller: wait for strobe, assert ready after rdy_dly extra strobe cycles,
    // then give nacks consecutive acks and a final done.
    task automatic serve(input int rdy_dly, input int nacks, input logic [15:0] base);
        int n;
        n = 0;
        while (!stb && n < 40) begin tick(); n++; end
        chk("stb_seen", 32'(stb), 32'd1);
        if (!rfsh) req = 1'b0;
        href = 1'b0;
        lref = 1'b0;
        repeat (rdy_dly) tick();
        rdy = 1'b1; tick(); rdy = 1'b0;
        for (int i = 0; i < nacks; i++) begin
            ack = 1'b1; mdat = base + 16'(i); tick();
        end
        ack = 1'b0; mdat = '0; mdone = 1'b1; tick(); mdone = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stb"}, 32'(stb), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_rfsh"}, 32'(rfsh), 0);
        chk({tag, "_wreq"}, 32'(wreq), 0);
        chk({tag, "_blen"}, 32'(blen), 0);
        chk({tag, "_adr"}, 32'(madr), 0);
        chk({tag, "_sel"}, 32'(msel), 0);
        chk({tag, "_mdat"}, 32'(mdat_o), 0);
        chk({tag, "_wack"}, 32'(wack), 0);
        chk({tag, "_hdat"}, 32'(hdat_o), 0);
        chk({tag, "_rval"}, 32'(rval), 0);
        chk({tag, "_done"}, 32'(hdone), 0);
        chk({tag, "_err"}, 32'(herr), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_stb, s_wack, s_rval, s_done, s_err, s_ed, s_rstb, s_rv, s_ack, n;
        fork
            compare_loop();
        join_none

        // Reset state
        tick(); tick();
        chk_all_zero("rst");
        rst_n = 1'b1;
        tick();

        // 1: single write, ready after 2 strobe cycles
        s_stb = n_stb; s_wack = n_wack; s_done = n_done; s_err = n_err;
        req = 1; we = 1; adr = 24'h000100; len = 0; sel = 2'b11; hdat = 16'hA5C3;
        serve(1, 1, 16'h0);
        tick();
        chk("w1_stb_cycles", 32'(n_stb - s_stb), 2);
        chk("w1_wack_cnt", 32'(n_wack - s_wack), 1);
        chk("w1_wdata", 32'(wd[wd.size() - 1]), 32'hA5C3);
        chk("w1_done_cnt", 32'(n_done - s_done), 1);
        chk("w1_err_cnt", 32'(n_err - s_err), 0);
        chk("w1_wreq", 32'(wreq), 1);
        chk("w1_blen", 32'(blen), 0);
        chk("w1_adr", 32'(madr), 32'h100);

        // 2: burst read, 8 beats
        s_rval = n_rval; s_done = n_done; s_err = n_err; s_rv = rv_dat.size(); s_ack = ack_cyc.size();
        req = 1; we = 0; adr = 24'h000200; len = 7; sel = 2'b11;
        serve(2, 8, 16'h1000);
        tick();
        chk("r8_rval_cnt", 32'(n_rval - s_rval), 8);
        for (int i = 0; i < 8; i++) begin
            chk("r8_data", 32'(rv_dat[s_rv + i]), 32'h1000 + 32'(i));
            chk("r8_lat", 32'(rv_cyc[s_rv + i] - ack_cyc[s_ack + i]), 1);
        end
        chk("r8_done_cnt", 32'(n_done - s_done), 1);
        chk("r8_err_cnt", 32'(n_err - s_err), 0);

        // 3: href and host request together: refresh first, host after one IDLE cycle
        s_done = n_done; s_rstb = n_rstb;
        href = 1; req = 1; we = 1; adr = 24'h000300; len = 0; sel = 2'b01; hdat = 16'hBEEF;
        serve(0, 0, 16'h0);
        chk("rf_stb_cnt", 32'(n_rstb - s_rstb), 1);
        chk("rf_no_done", 32'(n_done - s_done), 0);
        chk("rf_gap_idle", 32'(busy), 0);
        tick();
        chk("rf_host_stb", 32'(stb), 1);
        chk("rf_host_rfsh", 32'(rfsh), 0);
        serve(0, 1, 16'h0);

        // 4: low-priority refresh after LREF idle cycles
        lref = 1;
        n = 0;
        while (!stb && n < 20) begin tick(); n++; end
        chk("rf_host_done", 32'(n_done - s_done), 1);
        chk("lref_wait", 32'(n), 5);
        chk("lref_rfsh", 32'(rfsh), 1);
        serve(0, 0, 16'h0);
        lref = 1;
        tick(); tick();
        req = 1; we = 0; adr = 24'h000400; len = 0; sel = 2'b10;
        tick();
        chk("lref_host_wins", 32'(rfsh), 0);
        chk("lref_host_adr", 32'(madr), 32'h400);
        serve(0, 1, 16'h2222);
        tick();
        chk("lref_host_rdat", 32'(rv_dat[rv_dat.size() - 1]), 32'h2222);

        // 5: len=3 with 3 acks, then with 5 acks
        s_rval = n_rval; s_done = n_done; s_err = n_err; s_ed = n_errdone;
        req = 1; we = 0; adr = 24'h000500; len = 3; sel = 2'b11;
        serve(0, 3, 16'h3000);
        tick();
        chk("short_rval", 32'(n_rval - s_rval), 3);
        chk("short_done", 32'(n_done - s_done), 1);
        chk("short_err_with_done", 32'(n_errdone - s_ed), 1);
        s_rval = n_rval; s_done = n_done; s_ed = n_errdone;
        req = 1;
        serve(0, 5, 16'h3100);
        tick();
        chk("long_rval", 32'(n_rval - s_rval), 4);
        chk("long_done", 32'(n_done - s_done), 1);
        chk("long_err_with_done", 32'(n_errdone - s_ed), 1);

        // 6: async reset during beat 2 of an 8-beat read, then a clean write
        req = 1; we = 0; adr = 24'h000600; len = 7; sel = 2'b11;
        tick();
        req = 0;
        rdy = 1; tick(); rdy = 0;
        ack = 1; mdat = 16'h4000; tick();
        mdat = 16'h4001; tick();
        mdat = 16'h4002;
        chk("rst_busy_before", 32'(busy), 1);
        chk("rst_hdat_before", 32'(hdat_o), 32'h4001);
        rst_n = 0;
        #1;
        chk_all_zero("arst");
        ack = 0; mdat = '0;
        tick(); tick();
        rst_n = 1;
        tick();
        chk("post_rst_idle", 32'(busy), 0);
        s_done = n_done; s_wack = n_wack; s_err = n_err;
        req = 1; we = 1; adr = 24'h123456; len = 0; sel = 2'b01; hdat = 16'h5A5A;
        serve(0, 1, 16'h0);
        tick();
        chk("post_rst_done", 32'(n_done - s_done), 1);
        chk("post_rst_wack", 32'(n_wack - s_wack), 1);
        chk("post_rst_err", 32'(n_err - s_err), 0);
        chk("post_rst_wdata", 32'(wd[wd.size() - 1]), 32'h5A5A);
        chk("post_rst_adr", 32'(madr), 32'h123456);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/de0_mc_host.md
Name: de0_mc_host

Overview:
Initiator for the mc_* command interface of the DE0 SDR SDRAM controller. Accepts single or burst read/write requests from one host client. Schedules refreshes from the controller's low/high-priority requests. Issues commands with the strobe/ready handshake, and steers per-beat data using mc_ack and mc_done. Sits between the system hub and the SDRAM controller, one instance per controller.

Parameters:
DATA_SIZE, 16, data bus width (must match controller)
ADDR_SIZE, 24, word address width
LREF_IDLE, 4, consecutive idle cycles before a low-priority refresh is issued (1..15)

Ports:
mc_clk_i  in  1  system clock, all logic on rising edge
mc_rst_n  in  1  reset, asynchronous active-low
hst_req_i  in  1  host request, level; sampled only in IDLE
hst_we_i  in  1  1 = write, 0 = read
hst_adr_i  in  ADDR_SIZE  start word address
hst_len_i  in  3  beats minus one (0 = 1 beat, 7 = 8 beats)
hst_sel_i  in  DATA_SIZE/8  byte lane mask, passed through for the whole command
hst_dat_i  in  DATA_SIZE  write data, current beat
hst_wack_o  out  1  write beat consumed; host advances to next beat
hst_dat_o  out  DATA_SIZE  read data, registered
hst_rval_o  out  1  hst_dat_o valid (one pulse per beat)
hst_done_o  out  1  one-cycle pulse, host command finished
hst_err_o  out  1  one-cycle pulse with hst_done_o if ack count != len+1
hst_busy_o  out  1  block not in IDLE
mc_stb_o  out  1  command strobe
mc_rfsh_o  out  1  refresh command qualifier
mc_wreq_o  out  1  write command qualifier
mc_blen_o  out  3  burst length, latched hst_len_i
mc_adr_o  out  ADDR_SIZE  latched address
mc_sel_o  out  DATA_SIZE/8  latched byte mask
mc_dat_o  out  DATA_SIZE  write data to controller
mc_dat_i  in  DATA_SIZE  read data from controller
mc_rdy_i  in  1  controller ready for command
mc_ack_i  in  1  per-beat data acknowledge
mc_done_i  in  1  command completed
mc_lref_i  in  1  low-priority refresh request
mc_href_i  in  1  high-priority refresh request

Behaviour:
- Reset values: all outputs 0; state IDLE; beat and idle counters 0.
- States: IDLE, CMD, XFER, RWAIT.
- IDLE arbitration, evaluated in this order each cycle:
  - If mc_href_i: load refresh command (mc_rfsh_o=1, mc_wreq_o=0) and go to CMD.
  - Else if hst_req_i: latch we/adr/len/sel into mc_* registers and go to CMD.
  - Else if mc_lref_i and idle_cnt >= LREF_IDLE: load refresh command and go to CMD.
  - idle_cnt increments (saturating at 15) each IDLE cycle with no hst_req_i. It clears on leaving IDLE.
- CMD: mc_stb_o=1 and command fields stay stable. The handshake completes at the first rising edge with mc_stb_o & mc_rdy_i. On that edge mc_stb_o drops; the next state is XFER for host commands and RWAIT for refresh. Minimum strobe width is 1 cycle.
- XFER, write:
  - mc_dat_o = hst_dat_i (combinational).
  - hst_wack_o = mc_ack_i (combinational).
  - The host must present beat k before ack k.
- XFER, read: on each mc_ack_i, hst_dat_o <= mc_dat_i and hst_rval_o=1 in the following cycle. Read latency from ack is 1 cycle.
- XFER beat counter: 3+1 bits, incremented per ack. Acks beyond len+1 are ignored (no hst_wack_o/hst_rval_o) and set the error flag.
- XFER exit: on mc_done_i, go to IDLE. hst_done_o pulses on the next cycle. hst_err_o pulses with it if beats != len+1. mc_ack_i and mc_done_i in the same cycle count that beat first.
- RWAIT: wait for mc_done_i, then go to IDLE. There is no host pulse; mc_rfsh_o clears.
- mc_href_i/mc_lref_i changes during CMD/XFER/RWAIT are ignored until IDLE.
- hst_req_i while busy is not accepted. The host holds the request, and the block samples it again in IDLE. Back-to-back commands have at least 1 IDLE cycle between them.
- mc_adr_o is passed unchanged. Burst boundary alignment is the host's responsibility.
- mc_rst_n asserted mid-command: everything returns to reset values immediately (mc_stb_o=0). The controller is reset by the same power-up sequence.

Decomposition:
- Shared package de0_mc_pkg holds:
  - state encodings
  - DATA_SIZE/ADDR_SIZE defaults
  - blen width constant (3)
  - LREF_IDLE counter width
- No sub-module. The refresh arbiter is a few lines inside IDLE.

Test Plan:
- Single write: hst_req, we=1, adr=0x000100, len=0, dat=0xA5C3; controller rdy after 2 cycles, ack, done -> mc_stb_o high exactly 2 cycles, mc_wreq_o=1, mc_blen_o=0, one hst_wack_o, hst_done_o pulse, hst_err_o=0.
- Burst read, len=7: controller returns 0x1000..0x1007 on 8 acks -> 8 hst_rval_o pulses each 1 cycle after its ack with matching data, then hst_done_o.
- mc_href_i and hst_req_i asserted together in IDLE -> refresh issued first (mc_rfsh_o=1, mc_wreq_o=0, no host pulse). Host command follows after refresh done plus 1 IDLE cycle.
- mc_lref_i held with hst_req_i low -> refresh strobe appears only after 4 idle cycles. With hst_req_i asserted on idle cycle 2, the host command wins.
- len=3 read with controller giving 3 acks then done -> hst_done_o and hst_err_o pulse together. Repeat with 5 acks -> 5th ack produces no hst_rval_o, and hst_err_o=1.
- mc_rst_n low during XFER beat 2 of 8 -> all outputs 0 asynchronously. After release the state is IDLE and a new single write completes normally.
